// File: rtl/hs_byte_fifo.sv
// Byte FIFO bridging a dav_/rfd consumer port (input) to a dav_/rfd producer port (output).
// Define HS_BYTE_FIFO_LEVEL_EN to add the level and sticky overrun outputs.
module hs_byte_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic [7:0]   data_in,
    input  logic         dav_in_,
    output logic         rfd_in,
    output logic [7:0]   data_out,
    output logic         dav_out_,
    input  logic         rfd_out,
    output logic         full,
`ifdef HS_BYTE_FIFO_LEVEL_EN
    output logic [AW:0]  level,
    output logic         overrun,
`endif
    output logic         empty
);

    typedef enum logic {IN_IDLE, IN_ACK} in_st_t;
    typedef enum logic [1:0] {OUT_IDLE, OUT_ACK, OUT_REL} out_st_t;

    in_st_t        r_in_st;
    out_st_t       r_out_st;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_count, w_count_nxt;
    logic          r_rfd_in, r_dav_out_, r_full, r_empty;
    logic [7:0]    r_data_out;
    logic          w_push, w_pop;

    assign w_push = (r_in_st == IN_IDLE) && !dav_in_ && !r_full;
    assign w_pop  = (r_out_st == OUT_ACK) && !rfd_out;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + (AW+1)'(1);
        else if (w_pop && !w_push)
            w_count_nxt = r_count - (AW+1)'(1);
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clock)
        if (w_push) r_mem[r_wp] <= data_in;

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            r_in_st  <= IN_IDLE;
            r_wp     <= '0;
            r_rfd_in <= 1'b1;
        end else begin
            case (r_in_st)
                IN_IDLE: if (w_push) begin
                    r_wp     <= r_wp + AW'(1);
                    r_rfd_in <= 1'b0;
                    r_in_st  <= IN_ACK;
                end
                IN_ACK: if (dav_in_) begin
                    r_rfd_in <= 1'b1;
                    r_in_st  <= IN_IDLE;
                end
                default: r_in_st <= IN_IDLE;
            endcase
        end
    end

    // Head entry stays counted until the consumer acknowledges, so it cannot be overwritten.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            r_out_st   <= OUT_IDLE;
            r_rp       <= '0;
            r_dav_out_ <= 1'b1;
            r_data_out <= 8'h00;
        end else begin
            case (r_out_st)
                OUT_IDLE: if (r_count != '0) begin
                    r_data_out <= r_mem[r_rp];
                    r_dav_out_ <= 1'b0;
                    r_out_st   <= OUT_ACK;
                end
                OUT_ACK: if (!rfd_out) begin
                    r_dav_out_ <= 1'b1;
                    r_rp       <= r_rp + AW'(1);
                    r_out_st   <= OUT_REL;
                end
                OUT_REL: if (rfd_out) r_out_st <= OUT_IDLE;
                default: r_out_st <= OUT_IDLE;
            endcase
        end
    end

`ifdef HS_BYTE_FIFO_LEVEL_EN
    logic r_dav_in_q, r_overrun;
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            r_dav_in_q <= 1'b1;
            r_overrun  <= 1'b0;
        end else begin
            r_dav_in_q <= dav_in_;
            if (r_dav_in_q && !dav_in_ && r_full) r_overrun <= 1'b1;
        end
    end
    assign level   = r_count;
    assign overrun = r_overrun;
`endif

    assign rfd_in   = r_rfd_in;
    assign dav_out_ = r_dav_out_;
    assign data_out = r_data_out;
    assign full     = r_full;
    assign empty    = r_empty;

endmodule

// File: tb/tb_hs_byte_fifo.sv
// Self-checking bench for hs_byte_fifo: directed handshake scenarios plus a
// randomized producer/consumer run scored against a queue model.
module tb_hs_byte_fifo;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic       clock = 1'b0;
    logic       reset_ = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       dav_in_ = 1'b1;
    logic       rfd_out = 1'b1;
    logic       rfd_in, dav_out_, full, empty;
    logic [7:0] data_out;
`ifdef HS_BYTE_FIFO_LEVEL_EN
    logic [AW:0] level;
    logic        overrun;
`endif

    int checks = 0;
    int errors = 0;

    hs_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clock(clock), .reset_(reset_),
        .data_in(data_in), .dav_in_(dav_in_), .rfd_in(rfd_in),
        .data_out(data_out), .dav_out_(dav_out_), .rfd_out(rfd_out),
        .full(full),
`ifdef HS_BYTE_FIFO_LEVEL_EN
        .level(level), .overrun(overrun),
`endif
        .empty(empty)
    );

    always #5 clock = ~clock;

    // Full upstream handshake; entered and left on a negedge.
    task automatic push_byte(input logic [7:0] b, output bit ok);
        int n;
        ok = 1'b1; data_in = b; dav_in_ = 1'b0; n = 0;
        @(negedge clock);
        while (rfd_in !== 1'b0 && n < 200) begin @(negedge clock); n++; end
        if (rfd_in !== 1'b0) ok = 1'b0;
        dav_in_ = 1'b1;
        @(negedge clock);
        if (rfd_in !== 1'b1) ok = 1'b0;
    endtask

    task automatic pop_byte(output logic [7:0] b, output bit ok);
        int n;
        ok = 1'b1; n = 0;
        while (dav_out_ !== 1'b0 && n < 200) begin @(negedge clock); n++; end
        if (dav_out_ !== 1'b0) ok = 1'b0;
        b = data_out; rfd_out = 1'b0;
        @(negedge clock);
        if (dav_out_ !== 1'b1) ok = 1'b0;
        rfd_out = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_reset();
        int bad;
        #2 reset_ = 1'b0;
        #1;
        checks++;
        if (rfd_in !== 1'b1 || dav_out_ !== 1'b1 || empty !== 1'b1 || full !== 1'b0 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_asserted rfd_in=%b dav_out_=%b empty=%b full=%b data_out=%h want 1 1 1 0 00",
                     rfd_in, dav_out_, empty, full, data_out);
        end
        repeat (3) @(negedge clock);
        reset_ = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (rfd_in !== 1'b1 || dav_out_ !== 1'b1 || empty !== 1'b1 || full !== 1'b0 || data_out !== 8'h00) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_idle bad_cycles=%0d want 0 (last rfd_in=%b dav_out_=%b empty=%b full=%b data=%h)",
                     bad, rfd_in, dav_out_, empty, full, data_out);
        end
`ifdef HS_BYTE_FIFO_LEVEL_EN
        checks++;
        if (level !== '0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_level level=%0d overrun=%b want 0 0", level, overrun);
        end
`endif
    endtask

    task automatic test_single();
        data_in = 8'hA5; dav_in_ = 1'b0;
        @(negedge clock);
        checks++;
        if (rfd_in !== 1'b0 || dav_out_ !== 1'b1 || empty !== 1'b0) begin
            errors++;
            $display("FAIL single_push rfd_in=%b dav_out_=%b empty=%b want 0 1 0", rfd_in, dav_out_, empty);
        end
        dav_in_ = 1'b1;
        @(negedge clock);
        checks++;
        if (dav_out_ !== 1'b0 || data_out !== 8'hA5 || rfd_in !== 1'b1) begin
            errors++;
            $display("FAIL single_present dav_out_=%b data_out=%h rfd_in=%b want 0 a5 1", dav_out_, data_out, rfd_in);
        end
        rfd_out = 1'b0;
        @(negedge clock);
        checks++;
        if (dav_out_ !== 1'b1 || empty !== 1'b1) begin
            errors++;
            $display("FAIL single_pop dav_out_=%b empty=%b want 1 1", dav_out_, empty);
        end
        rfd_out = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_fill_stall();
        bit ok; logic [7:0] b; int stall_bad; int n;
        for (int i = 1; i <= DEPTH; i++) begin
            push_byte(8'(i), ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL fill_push byte=%0d handshake incomplete", i); end
        end
        checks++;
        if (full !== 1'b1 || empty !== 1'b0) begin
            errors++;
            $display("FAIL fill_full full=%b empty=%b want 1 0", full, empty);
        end
        data_in = 8'h09; dav_in_ = 1'b0;
        stall_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (rfd_in !== 1'b1) stall_bad++;
        end
        checks++;
        if (stall_bad != 0) begin
            errors++;
            $display("FAIL fill_stall rfd_in_low_cycles=%0d want 0", stall_bad);
        end
`ifdef HS_BYTE_FIFO_LEVEL_EN
        checks++;
        if (level !== 4'(DEPTH) || overrun !== 1'b1) begin
            errors++;
            $display("FAIL fill_level level=%0d overrun=%b want %0d 1", level, overrun, DEPTH);
        end
`endif
        pop_byte(b, ok);
        checks++;
        if (!ok || b !== 8'h01) begin
            errors++;
            $display("FAIL fill_first_pop got=%h ok=%0d want 01 1", b, ok);
        end
        n = 0;
        while (rfd_in !== 1'b0 && n < 20) begin @(negedge clock); n++; end
        checks++;
        if (rfd_in !== 1'b0) begin
            errors++;
            $display("FAIL fill_release rfd_in=%b want 0 after one pop", rfd_in);
        end
        dav_in_ = 1'b1;
        @(negedge clock);
        for (int i = 2; i <= DEPTH + 1; i++) begin
            pop_byte(b, ok);
            checks++;
            if (!ok || b !== 8'(i)) begin
                errors++;
                $display("FAIL fill_drain got=%h ok=%0d want %h", b, ok, 8'(i));
            end
        end
        checks++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            errors++;
            $display("FAIL fill_end empty=%b full=%b want 1 0", empty, full);
        end
    endtask

    task automatic test_wrap();
        bit ok; logic [7:0] b; int bad;
        push_byte(8'h00, ok);
        push_byte(8'h01, ok);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (i + 2 < 20) begin
                push_byte(8'(i + 2), ok);
                if (!ok) bad++;
            end
            pop_byte(b, ok);
            checks++;
            if (!ok || b !== 8'(i)) begin
                errors++;
                $display("FAIL wrap_order got=%h ok=%0d want %h", b, ok, 8'(i));
            end
        end
        checks++;
        if (bad != 0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL wrap_end push_failures=%0d empty=%b want 0 1", bad, empty);
        end
    endtask

    task automatic test_simultaneous();
        bit ok; logic [7:0] b;
        push_byte(8'h31, ok);
        push_byte(8'h32, ok);
        push_byte(8'h33, ok);
        checks++;
        if (dav_out_ !== 1'b0 || data_out !== 8'h31) begin
            errors++;
            $display("FAIL simul_head dav_out_=%b data_out=%h want 0 31", dav_out_, data_out);
        end
        data_in = 8'h3C; dav_in_ = 1'b0; rfd_out = 1'b0;
        @(negedge clock);
        checks++;
        if (rfd_in !== 1'b0 || dav_out_ !== 1'b1 || empty !== 1'b0 || full !== 1'b0) begin
            errors++;
            $display("FAIL simul_edge rfd_in=%b dav_out_=%b empty=%b full=%b want 0 1 0 0",
                     rfd_in, dav_out_, empty, full);
        end
        dav_in_ = 1'b1; rfd_out = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            pop_byte(b, ok);
            checks++;
            if (!ok || b !== (i == 0 ? 8'h32 : i == 1 ? 8'h33 : 8'h3C)) begin
                errors++;
                $display("FAIL simul_drain idx=%0d got=%h ok=%0d", i, b, ok);
            end
            checks++;
            if (empty !== (i == 2)) begin
                errors++;
                $display("FAIL simul_empty idx=%0d empty=%b want %0d", i, empty, (i == 2));
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok; logic [7:0] b;
        push_byte(8'h41, ok);
        push_byte(8'h42, ok);
        push_byte(8'h43, ok);
        data_in = 8'h44; dav_in_ = 1'b0;
        @(negedge clock);
        checks++;
        if (rfd_in !== 1'b0 || dav_out_ !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_setup rfd_in=%b dav_out_=%b want 0 0", rfd_in, dav_out_);
        end
        #2 reset_ = 1'b0;
        #1;
        checks++;
        if (rfd_in !== 1'b1 || dav_out_ !== 1'b1 || empty !== 1'b1 || full !== 1'b0 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_async rfd_in=%b dav_out_=%b empty=%b full=%b data=%h want 1 1 1 0 00",
                     rfd_in, dav_out_, empty, full, data_out);
        end
        dav_in_ = 1'b1;
        @(negedge clock);
        reset_ = 1'b1;
        @(negedge clock);
        push_byte(8'h77, ok);
        pop_byte(b, ok);
        checks++;
        if (!ok || b !== 8'h77 || empty !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_first got=%h ok=%0d empty=%b want 77 1 1", b, ok, empty);
        end
    endtask

    task automatic test_random();
        logic [7:0] model[$];
        fork
            begin : producer
                bit pok; logic [7:0] pb;
                for (int i = 0; i < 60; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clock);
                    pb = 8'($urandom);
                    model.push_back(pb);
                    push_byte(pb, pok);
                    checks++;
                    if (!pok) begin errors++; $display("FAIL rand_push idx=%0d handshake incomplete", i); end
                end
            end
            begin : consumer
                bit cok; logic [7:0] cb, exp;
                for (int i = 0; i < 60; i++) begin
                    repeat ($urandom_range(0, 6)) @(negedge clock);
                    pop_byte(cb, cok);
                    exp = (model.size() > 0) ? model.pop_front() : 8'hxx;
                    checks++;
                    if (!cok || cb !== exp) begin
                        errors++;
                        $display("FAIL rand_pop idx=%0d got=%h ok=%0d want %h", i, cb, cok, exp);
                    end
                end
            end
        join
        checks++;
        if (empty !== 1'b1 || model.size() != 0) begin
            errors++;
            $display("FAIL rand_end empty=%b leftover=%0d want 1 0", empty, model.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_stall();
        test_wrap();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
